gcd_regfile: RTL
================

Name: gcd_regfile

Overview:
- Parametrised register bank that replaces the single 4-bit enable/reset register in the GCD FSMD datapath.
- Holds DEPTH words of WIDTH bits and exposes two combinational read ports.
- Executes one datapath operation per cycle under FSM control: load, subtract, swap or clear.
- Produces registered compare flags and per-entry valid bits, so the controller needs no external comparator or registers.

Parameters:
- WIDTH, 4, data word width in bits (>=2).
- DEPTH, 4, number of entries (>=2, power of two).
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- CLK  in  1  clock; all state updates on the falling edge.
- RESET  in  1  synchronous, active-high reset, sampled on the falling edge of CLK.
- OP  in  2  operation: 00 hold, 01 load, 10 subtract, 11 swap.
- CLR  in  1  clear entry WADDR to 0 and drop its valid bit.
- WADDR  in  AW  destination entry for load, subtract and clear.
- WDATA  in  WIDTH  load data.
- RADDR_A  in  AW  read/operand address A.
- RADDR_B  in  AW  read/operand address B.
- RDATA_A  out  WIDTH  combinational contents of entry RADDR_A.
- RDATA_B  out  WIDTH  combinational contents of entry RADDR_B.
- VALID  out  DEPTH  bit i set when entry i holds loaded or computed data.
- A_EQ_B  out  1  registered: RDATA_A == RDATA_B, sampled at the last edge.
- A_LT_B  out  1  registered: RDATA_A < RDATA_B (unsigned), sampled at the last edge.
- BORROW  out  1  registered: the last subtract underflowed.
- OP_CNT  out  16  count of non-hold operations executed since reset; saturates at 16'hFFFF.

Behaviour:
- Initial and reset state: all entries 0; VALID=0; A_EQ_B=1 (0==0); A_LT_B=0; BORROW=0; OP_CNT=0.
- Priority at each falling edge: RESET > CLR > OP.
  - RESET high: full reset; CLR and OP are ignored.
  - RESET mid-sequence: takes effect that edge; there is no partial update.
- CLR=1: entry[WADDR]<=0; VALID[WADDR]<=0; OP is ignored that cycle; OP_CNT increments.
- OP=00 hold: no entry, valid bit or BORROW change; OP_CNT unchanged.
- OP=01 load: entry[WADDR]<=WDATA; VALID[WADDR]<=1.
- OP=10 subtract:
  - entry[WADDR] <= (RDATA_A - RDATA_B) mod 2^WIDTH; VALID[WADDR]<=1.
  - BORROW <= (RDATA_A < RDATA_B).
  - Operands are the pre-edge values, so WADDR may equal RADDR_A or RADDR_B.
- OP=11 swap:
  - entry[RADDR_A]<=old entry[RADDR_B] and entry[RADDR_B]<=old entry[RADDR_A].
  - VALID bits swap with the data.
  - RADDR_A==RADDR_B is a no-op on data but still counts as an operation.
  - WADDR and WDATA are ignored.
- BORROW updates only on subtract and holds otherwise; it clears on RESET.
- Compare flags:
  - A_EQ_B and A_LT_B update every non-reset edge from the pre-edge RDATA_A/RDATA_B.
  - They lag the read-port contents by one cycle; the FSM treats them as previous-cycle status.
- Read ports: purely combinational from the current array; no write-through bypass. A write is visible on RDATA after the edge that performs it.
- OP_CNT: +1 on each edge with CLR=1 or OP!=00 and RESET=0; holds at 16'hFFFF (no wrap).
- Latency: one falling edge from inputs to entry, valid bit and flag update.
- Out-of-range addresses are impossible (DEPTH is a power of two).
- X-safety: with OP=00 and CLR=0, unknown WDATA must not disturb state.

Test Plan:
- Reset: drive RESET=1 for 1 edge with OP=01, WADDR=0, WDATA=4'h9 -> entry0=0, VALID=4'b0000, A_EQ_B=1, A_LT_B=0, BORROW=0, OP_CNT=0.
- Load/read:
  - Load 12 into entry0, then 8 into entry1; set RADDR_A=0, RADDR_B=1.
  - Required: RDATA_A=12, RDATA_B=8, VALID=4'b0011, OP_CNT=2.
  - One edge later: A_EQ_B=0, A_LT_B=0.
- GCD(12,8) via subtract and swap:
  - Subtract into entry0 -> 4, BORROW=0.
  - Then A_LT_B=1; swap -> entry0=8, entry1=4.
  - Subtract -> 4; one edge later A_EQ_B=1; final entries 4,4; OP_CNT=5.
- Underflow: entry2=3, entry3=5, subtract A=2, B=3 into entry2 -> entry2=4'hE, BORROW=1. A following hold leaves BORROW=1.
- Priority and simultaneous events:
  - CLR=1 with OP=01 on WADDR=1 -> entry1=0, VALID[1]=0, WDATA not written.
  - RESET=1 with CLR=1 -> full reset.
- Saturation and swap self-address:
  - Force OP_CNT to 16'hFFFE by running ops, issue 3 more ops -> OP_CNT=16'hFFFF.
  - Swap with RADDR_A=RADDR_B=2 -> data unchanged, count stays saturated.

Source files
------------

// File: rtl/gcd_regfile.sv
// Register bank for the GCD FSMD datapath. It performs one load, subtract, swap or clear per
// falling clock edge and provides registered compare and borrow flags for the controller.
module gcd_regfile #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       OP,
  input  logic             CLR,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR_A,
  input  logic [AW-1:0]    RADDR_B,
  output logic [WIDTH-1:0] RDATA_A,
  output logic [WIDTH-1:0] RDATA_B,
  output logic [DEPTH-1:0] VALID,
  output logic             A_EQ_B,
  output logic             A_LT_B,
  output logic             BORROW,
  output logic [15:0]      OP_CNT
);

  localparam logic [1:0]  OP_HOLD = 2'b00;
  localparam logic [1:0]  OP_LOAD = 2'b01;
  localparam logic [1:0]  OP_SUB  = 2'b10;
  localparam logic [1:0]  OP_SWAP = 2'b11;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [WIDTH-1:0]            diff;
  logic                        counts;

  assign RDATA_A = mem[RADDR_A];
  assign RDATA_B = mem[RADDR_B];
  assign diff    = RDATA_A - RDATA_B;
  assign counts  = CLR || (OP != OP_HOLD);

  // Operands come from the pre-edge array, so WADDR may alias either read address.
  always_ff @(negedge CLK) begin
    if (RESET) begin
      mem    <= '0;
      VALID  <= '0;
      A_EQ_B <= 1'b1;
      A_LT_B <= 1'b0;
      BORROW <= 1'b0;
      OP_CNT <= '0;
    end else begin
      A_EQ_B <= (RDATA_A == RDATA_B);
      A_LT_B <= (RDATA_A <  RDATA_B);
      if (counts && OP_CNT != CNT_MAX) OP_CNT <= OP_CNT + 16'd1;
      if (CLR) begin
        mem[WADDR]   <= '0;
        VALID[WADDR] <= 1'b0;
      end else begin
        case (OP)
          OP_LOAD: begin
            mem[WADDR]   <= WDATA;
            VALID[WADDR] <= 1'b1;
          end
          OP_SUB: begin
            mem[WADDR]   <= diff;
            VALID[WADDR] <= 1'b1;
            BORROW       <= (RDATA_A < RDATA_B);
          end
          OP_SWAP: begin
            mem[RADDR_A]   <= mem[RADDR_B];
            mem[RADDR_B]   <= mem[RADDR_A];
            VALID[RADDR_A] <= VALID[RADDR_B];
            VALID[RADDR_B] <= VALID[RADDR_A];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
